permutation_sequencer: RTL and testbench

Sequences the Ascon permutation p^a / p^b over a registered 320-bit state, one round per clock. Each round applies constant addition, the existing `substitution_layer`, and the linear diffusion layer, with the round counter generated here. Sits between the top-level Ascon mode FSM (initialisation, associated data, plaintext, finalisation) and the round datapath. The mode FSM only issues start/mode and collects the result.

---
 rtl/permutation_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_permutation_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/permutation_sequencer.sv
// ---------------------------------------------------------------------------
// permutation_sequencer
//
// Runs the Ascon permutation p^a (12 rounds) or p^b (6 rounds) on a
// registered 320-bit state, one round per clock. The round datapath is
// constant addition, then substitution_layer, then the linear diffusion
// layer. It is one combinational path from state_q back to state_q.
//
// Ports:
//   clock_i  in   system clock, rising edge
//   reset_i  in   synchronous active-high reset
//   start_i  in   request a permutation (sampled only when ready_o = 1)
//   mode_i   in   1 = p^a (rounds 0..11), 0 = p^b (rounds 6..11)
//   state_i  in   state to permute, sampled with an accepted start
//   state_o  out  state register contents
//   round_o  out  current round index
//   ready_o  out  a start is accepted this cycle
//   done_o   out  one-cycle pulse; state_o holds the permuted state
//
// Optional feature macro: PERM_BACK_TO_BACK_EN
//   When defined, the DONE cycle also accepts a new start. The next
//   permutation then begins without passing through IDLE.
// ---------------------------------------------------------------------------

package ascon_pack;
  // Word i of the packed array is Ascon word x_i.
  typedef logic [4:0][63:0] type_state;
endpackage

// Bit-sliced 5-bit Ascon S-box applied to all 64 columns at once.
module substitution_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;

  assign a0 = state_i[0] ^ state_i[4];
  assign a1 = state_i[1];
  assign a2 = state_i[2] ^ state_i[1];
  assign a3 = state_i[3];
  assign a4 = state_i[4] ^ state_i[3];

  // Chi-like nonlinear step.
  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign state_o[0] = b0 ^ b4;
  assign state_o[1] = b1 ^ b0;
  assign state_o[2] = ~b2;
  assign state_o[3] = b3 ^ b2;
  assign state_o[4] = b4;
endmodule

module permutation_sequencer
  import ascon_pack::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        mode_i,
  input  type_state   state_i,
  output type_state   state_o,
  output logic [3:0]  round_o,
  output logic        ready_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  fsm_t        fsm_q, fsm_d;
  type_state   state_q, state_d;
  logic [3:0]  round_q, round_d;

  type_state   const_out;
  type_state   sbox_out;
  type_state   lin_out;
  logic [7:0]  round_const;

  // Rotate right. The amount is never zero here, so the left shift stays below 64.
  function automatic logic [63:0] ror(input logic [63:0] x, input logic [5:0] n);
    ror = (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

  // Round constant: the high nibble counts down while the low nibble counts up.
  assign round_const = {4'd15 - round_q, round_q};

  // Constant addition touches only the low byte of x2.
  always_comb begin
    const_out       = state_q;
    const_out[2][7:0] = state_q[2][7:0] ^ round_const;
  end

  substitution_layer u_sbox (
    .state_i (const_out),
    .state_o (sbox_out)
  );

  assign lin_out[0] = sbox_out[0] ^ ror(sbox_out[0], 6'd19) ^ ror(sbox_out[0], 6'd28);
  assign lin_out[1] = sbox_out[1] ^ ror(sbox_out[1], 6'd61) ^ ror(sbox_out[1], 6'd39);
  assign lin_out[2] = sbox_out[2] ^ ror(sbox_out[2], 6'd1)  ^ ror(sbox_out[2], 6'd6);
  assign lin_out[3] = sbox_out[3] ^ ror(sbox_out[3], 6'd10) ^ ror(sbox_out[3], 6'd17);
  assign lin_out[4] = sbox_out[4] ^ ror(sbox_out[4], 6'd7)  ^ ror(sbox_out[4], 6'd41);

  // State register, round counter and FSM register, with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state logic: load on an accepted start, apply one round per RUN cycle.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          round_d = mode_i ? 4'd0 : 4'd6;
          fsm_d   = RUN;
        end else begin
          fsm_d   = IDLE;
        end
      end
      RUN: begin
        state_d = lin_out;
        // ">=" also recovers from an out-of-range counter.
        if (round_q >= LAST_ROUND) begin
          round_d = LAST_ROUND;
          fsm_d   = DONE;
        end else begin
          round_d = round_q + 4'd1;
          fsm_d   = RUN;
        end
      end
      DONE: begin
`ifdef PERM_BACK_TO_BACK_EN
        if (start_i) begin
          state_d = state_i;
          round_d = mode_i ? 4'd0 : 4'd6;
          fsm_d   = RUN;
        end else begin
          fsm_d   = IDLE;
        end
`else
        fsm_d = IDLE;
`endif
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign done_o  = (fsm_q == DONE);
`ifdef PERM_BACK_TO_BACK_EN
  assign ready_o = (fsm_q == IDLE) || (fsm_q == DONE);
`else
  assign ready_o = (fsm_q == IDLE);
`endif

endmodule

// File: tb/tb_permutation_sequencer.sv
module tb_permutation_sequencer;
  import ascon_pack::*;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       mode_i;
  type_state  state_i;
  type_state  state_o;
  logic [3:0] round_o;
  logic       ready_o;
  logic       done_o;

  permutation_sequencer dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .state_i (state_i),
    .state_o (state_o),
    .round_o (round_o),
    .ready_o (ready_o),
    .done_o  (done_o)
  );

  always #5 clock_i = ~clock_i;

`ifdef PERM_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  type_state sb[$];

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  typedef struct {
    type_state st;
    logic      mode;
    type_state exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[j] = x[(j + n) % 64];
    return y;
  endfunction

  function automatic type_state mk(input logic [63:0] x0, input logic [63:0] x1,
                                   input logic [63:0] x2, input logic [63:0] x3,
                                   input logic [63:0] x4);
    type_state s;
    s[0] = x0; s[1] = x1; s[2] = x2; s[3] = x3; s[4] = x4;
    return s;
  endfunction

  // Reference permutation: table S-box applied column by column.
  function automatic type_state model_perm(input type_state s_in, input logic m);
    type_state  s;
    type_state  t;
    logic [3:0] rr;
    logic [4:0] idx;
    logic [4:0] o;
    s = s_in;
    for (int r = (m ? 0 : 6); r < 12; r++) begin
      rr = r[3:0];
      s[2][7:0] = s[2][7:0] ^ {4'd15 - rr, rr};
      for (int c = 0; c < 64; c++) begin
        idx = {s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]};
        o   = SBOX[idx];
        t[0][c] = o[4]; t[1][c] = o[3]; t[2][c] = o[2]; t[3][c] = o[1]; t[4][c] = o[0];
      end
      s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
      s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
      s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
      s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
      s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
    end
    return s;
  endfunction

  function automatic type_state rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clock_i) begin
    if (reset_i === 1'b0 && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 320'(done_o), 320'(0));
      end else begin
        chk("result", state_o, sb.pop_front());
      end
    end
  end

  // Called at a negedge while idle; returns at the negedge after DONE.
  task automatic run_vec(input vec_t v);
    int first;
    int n;
    first = v.mode ? 0 : 6;
    n     = 12 - first;
    chk("ready_before", 320'(ready_o), 320'(1));
    start_i = 1'b1; state_i = v.st; mode_i = v.mode;
    sb.push_back(v.exp);
    @(negedge clock_i);
    start_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("round", 320'(round_o), 320'(first + k));
      chk("done_early", 320'(done_o), 320'(0));
      @(negedge clock_i);
    end
    chk("done_pulse", 320'(done_o), 320'(1));
    chk("ready_in_done", 320'(ready_o), 320'(B2B));
    chk("round_in_done", 320'(round_o), 320'(11));
    @(negedge clock_i);
    chk("done_after", 320'(done_o), 320'(0));
    chk("ready_idle", 320'(ready_o), 320'(1));
  endtask

  initial begin
    type_state s;
    int p;
    bit exp_done;

    vecs[0].st = mk(64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                    64'h0001020304050607, 64'h08090A0B0C0D0E0F);
    vecs[0].mode = 1'b1;
    vecs[1].st = '0;       vecs[1].mode = 1'b0;
    vecs[2].st = '0;       vecs[2].mode = 1'b1;
    vecs[3].st = '1;       vecs[3].mode = 1'b0;
    vecs[4].st = rand_state(); vecs[4].mode = 1'b1;
    foreach (vecs[i]) vecs[i].exp = model_perm(vecs[i].st, vecs[i].mode);

    // Reset held for two cycles while start is requested.
    reset_i = 1'b1; start_i = 1'b1; mode_i = 1'b1; state_i = vecs[0].st;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock_i);
      chk("rst_ready", 320'(ready_o), 320'(1));
      chk("rst_done",  320'(done_o),  320'(0));
      chk("rst_state", state_o, 320'(0));
      chk("rst_round", 320'(round_o), 320'(0));
    end
    reset_i = 1'b0; start_i = 1'b0;
    @(negedge clock_i);

    // Table-driven single permutations.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      if (i == 1) begin
        repeat (4) @(negedge clock_i);
        chk("hold_after_done", state_o, vecs[1].exp);
      end
    end

    // Start pulses and input churn while busy must be ignored.
    start_i = 1'b1; state_i = vecs[0].st; mode_i = 1'b1;
    sb.push_back(vecs[0].exp);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock_i);
      chk("churn_round", 320'(round_o), 320'(c - 1));
      start_i = (c == 3 || c == 5);
      state_i = rand_state();
      mode_i  = ~mode_i;
    end
    start_i = 1'b0;
    @(negedge clock_i);
    chk("churn_done", 320'(done_o), 320'(1));
    @(negedge clock_i);

    // Reset in cycle 4 of a p^a run aborts it.
    start_i = 1'b1; state_i = vecs[0].st; mode_i = 1'b1;
    sb.push_back(vecs[0].exp);
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (3) @(negedge clock_i);
    reset_i = 1'b1;
    sb.delete();
    @(negedge clock_i);
    reset_i = 1'b0;
    chk("abort_state", state_o, 320'(0));
    chk("abort_ready", 320'(ready_o), 320'(1));
    chk("abort_round", 320'(round_o), 320'(0));
    repeat (12) begin
      chk("abort_no_done", 320'(done_o), 320'(0));
      @(negedge clock_i);
    end
    run_vec(vecs[0]);

    // Start held high: p^b back-to-back.
    p = B2B ? 7 : 8;
    for (int c = 0; c <= 3 * p + 8; c++) begin
      exp_done = (c >= 7) && (((c - 7) % p) == 0) && (((c - 7) / p) <= 3);
      chk("b2b_done", 320'(done_o), 320'(exp_done));
      if ((c % p) == 0 && c <= 3 * p) begin
        s = rand_state();
        state_i = s; mode_i = 1'b0;
        sb.push_back(model_perm(s, 1'b0));
      end
      start_i = (c <= 3 * p);
      @(negedge clock_i);
    end
    start_i = 1'b0;
    repeat (3) @(negedge clock_i);

    chk("sb_empty", 320'(sb.size()), 320'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
